// File: rtl/turn_sequencer.sv
// Turn sequencer for a two-player artillery game: aim, fire, track the flight,
// animate the crater, apply damage and hand the turn over.
module turn_sequencer #(
  parameter int ANGLE_INIT = 4,
  parameter int POWER_INIT = 3,
  parameter int R_MAX      = 16,
  parameter int TIMEOUT    = 600,
  parameter int HP_INIT    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       key_l,
  input  logic       key_r,
  input  logic       key_u,
  input  logic       key_d,
  input  logic       key_fire,
  input  logic [9:0] tank0_x,
  input  logic [9:0] tank0_y,
  input  logic [9:0] tank1_x,
  input  logic [9:0] tank1_y,
  input  logic       boomed,
  input  logic       hit0,
  input  logic       hit1,
  output logic       launch,
  output logic [9:0] launchX,
  output logic [9:0] launchY,
  output logic [3:0] angle,
  output logic [2:0] power,
  output logic [9:0] boomRadius,
  output logic       player,
  output logic [1:0] hp0,
  output logic [1:0] hp1,
  output logic       game_over,
  output logic       winner
);

  localparam logic [2:0] AIM     = 3'd0;
  localparam logic [2:0] FIRE    = 3'd1;
  localparam logic [2:0] FLIGHT  = 3'd2;
  localparam logic [2:0] EXPLODE = 3'd3;
  localparam logic [2:0] SHRINK  = 3'd4;
  localparam logic [2:0] NEXT    = 3'd5;
  localparam logic [2:0] OVER    = 3'd6;

  localparam logic [3:0] ANG_RST = 4'(ANGLE_INIT);
  localparam logic [2:0] PWR_RST = 3'(POWER_INIT);
  localparam logic [1:0] HP_RST  = 2'(HP_INIT);
  localparam logic [9:0] RAD_MAX = 10'(R_MAX);
  localparam logic [9:0] TMO     = 10'(TIMEOUT);

  function automatic logic [1:0] hp_dec(input logic [1:0] h);
    return (h == 2'd0) ? h : h - 2'd1;
  endfunction

  logic [2:0] state_q, state_d;
  logic [4:0] keys_q, keys_d;
  logic [3:0] angle_q, angle_d;
  logic [2:0] power_q, power_d;
  logic [9:0] radius_q, radius_d;
  logic [9:0] cnt_q, cnt_d;
  logic       flag0_q, flag0_d, flag1_q, flag1_d;
  logic       player_q, player_d;
  logic [1:0] hp0_q, hp0_d, hp1_q, hp1_d;
  logic       winner_q, winner_d;

  logic [4:0] keys_now;
  logic [4:0] rise;

  // Bit order: 0=left 1=right 2=up 3=down 4=fire
  assign keys_now = {key_fire, key_d, key_u, key_r, key_l};
  assign rise     = keys_now & ~keys_q;

  always_comb begin
    state_d  = state_q;
    keys_d   = keys_now;
    angle_d  = angle_q;
    power_d  = power_q;
    radius_d = radius_q;
    cnt_d    = cnt_q;
    flag0_d  = flag0_q;
    flag1_d  = flag1_q;
    player_d = player_q;
    hp0_d    = hp0_q;
    hp1_d    = hp1_q;
    winner_d = winner_q;
    case (state_q)
      AIM: begin
        if (rise[4]) begin
          state_d = FIRE;
        end else begin
          if (rise[0] && !rise[1] && angle_q != 4'd0)      angle_d = angle_q - 4'd1;
          else if (rise[1] && !rise[0] && angle_q != 4'd8) angle_d = angle_q + 4'd1;
          if (rise[2] && !rise[3] && power_q != 3'd7)      power_d = power_q + 3'd1;
          else if (rise[3] && !rise[2] && power_q != 3'd0) power_d = power_q - 3'd1;
        end
      end
      FIRE: begin
        if (!boomed) begin
          state_d = FLIGHT;
          cnt_d   = 10'd0;
        end
      end
      FLIGHT: begin
        if (boomed) begin
          state_d  = EXPLODE;
          radius_d = 10'd0;
        end else if (cnt_q == TMO) begin
          state_d = NEXT;
        end else if (frame_tick) begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      EXPLODE: begin
        flag0_d = flag0_q | hit0;
        flag1_d = flag1_q | hit1;
        if (radius_q == RAD_MAX)  state_d  = SHRINK;
        else if (frame_tick)      radius_d = radius_q + 10'd1;
      end
      SHRINK: begin
        if (radius_q == 10'd0)    state_d  = NEXT;
        else if (frame_tick)      radius_d = radius_q - 10'd1;
      end
      NEXT: begin
        hp0_d   = flag0_q ? hp_dec(hp0_q) : hp0_q;
        hp1_d   = flag1_q ? hp_dec(hp1_q) : hp1_q;
        flag0_d = 1'b0;
        flag1_d = 1'b0;
        cnt_d   = 10'd0;
        if (hp0_d == 2'd0 || hp1_d == 2'd0) begin
          state_d = OVER;
          // A mutual kill goes to whoever fired the shot
          winner_d = (hp0_d == 2'd0 && hp1_d == 2'd0) ? player_q : (hp0_d == 2'd0);
        end else begin
          state_d  = AIM;
          player_d = ~player_q;
          angle_d  = ANG_RST;
          power_d  = PWR_RST;
        end
      end
      OVER:    state_d = OVER;
      default: state_d = AIM;
    endcase
    if (state_d != EXPLODE && state_d != SHRINK) radius_d = 10'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= AIM;
      keys_q   <= 5'd0;
      angle_q  <= ANG_RST;
      power_q  <= PWR_RST;
      radius_q <= 10'd0;
      cnt_q    <= 10'd0;
      flag0_q  <= 1'b0;
      flag1_q  <= 1'b0;
      player_q <= 1'b0;
      hp0_q    <= HP_RST;
      hp1_q    <= HP_RST;
      winner_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      keys_q   <= keys_d;
      angle_q  <= angle_d;
      power_q  <= power_d;
      radius_q <= radius_d;
      cnt_q    <= cnt_d;
      flag0_q  <= flag0_d;
      flag1_q  <= flag1_d;
      player_q <= player_d;
      hp0_q    <= hp0_d;
      hp1_q    <= hp1_d;
      winner_q <= winner_d;
    end
  end

  assign launch     = (state_q == FIRE);
  assign launchX    = player_q ? tank1_x : tank0_x;
  assign launchY    = player_q ? tank1_y : tank0_y;
  assign angle      = angle_q;
  assign power      = power_q;
  assign boomRadius = radius_q;
  assign player     = player_q;
  assign hp0        = hp0_q;
  assign hp1        = hp1_q;
  assign game_over  = (state_q == OVER);
  assign winner     = winner_q;

endmodule
